wb_unit: RTL and testbench

Registered writeback stage for the RV32I pipeline, generalised to XLEN 32/64. Selects the writeback source (ALU/shifter, load, PC+4), aligns and sign/zero-extends load data, and stalls on a late load response. Drives the register-file write port and WB forwarding path from a MEM/WB register, and keeps a retired-instruction counter.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_unit_if.sv | 40 ++++
 rtl/load_align.sv | 61 ++++++
 rtl/wb_unit.sv | 90 +++++++++
 tb/tb_wb_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source-select codes and load funct3 values.
package wb_pkg;

  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_MEM = 2'b01;
  localparam logic [1:0] WB_SRC_PC4 = 2'b10;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_f3_e;

endpackage

// File: rtl/wb_unit_if.sv
// MEM/WB slot, flush/stall handshake and register-file write port of the writeback stage.
interface wb_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) ();

  localparam int OFF_W = $clog2(XLEN/8);

  logic             VALID_MW;
  logic             RegWrite_MW;
  logic [4:0]       RD_MW;
  logic [1:0]       MemtoReg_MW;
  logic [2:0]       Funct3_MW;
  logic [OFF_W-1:0] ADDR_LO_MW;
  logic [XLEN-1:0]  MEM_DATA_MW;
  logic             MEM_RDY_MW;
  logic [XLEN-1:0]  PC4_MW;
  logic [XLEN-1:0]  RD_VAL_MW;
  logic             FLUSH_WB;
  logic             STALL_WB;
  logic             RF_WE;
  logic [4:0]       RF_WADDR;
  logic [XLEN-1:0]  RF_WDATA;
  logic             EXC_MISALIGN;
  logic             EXC_ILLEGAL;
  logic [CNT_W-1:0] INSTRET;

  modport master (
    output VALID_MW, RegWrite_MW, RD_MW, MemtoReg_MW, Funct3_MW, ADDR_LO_MW,
           MEM_DATA_MW, MEM_RDY_MW, PC4_MW, RD_VAL_MW, FLUSH_WB,
    input  STALL_WB, RF_WE, RF_WADDR, RF_WDATA, EXC_MISALIGN, EXC_ILLEGAL, INSTRET
  );

  modport slave (
    input  VALID_MW, RegWrite_MW, RD_MW, MemtoReg_MW, Funct3_MW, ADDR_LO_MW,
           MEM_DATA_MW, MEM_RDY_MW, PC4_MW, RD_VAL_MW, FLUSH_WB,
    output STALL_WB, RF_WE, RF_WADDR, RF_WDATA, EXC_MISALIGN, EXC_ILLEGAL, INSTRET
  );

endinterface

// File: rtl/load_align.sv
// Combinational load-data extraction: picks the addressed byte/half/word/double,
// sign- or zero-extends it to XLEN and flags illegal or misaligned accesses.
module load_align
  import wb_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  word,
  output logic [XLEN-1:0]  data,
  output logic             misalign,
  output logic             illegal
);

  logic [XLEN-1:0] shifted;

  assign shifted = word >> {offset, 3'b000};

  // Misalignment is only reported for legal encodings, so an illegal funct3 raises one flag.
  always_comb begin
    data     = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      LB:  data = XLEN'($signed(shifted[7:0]));
      LBU: data = XLEN'(shifted[7:0]);
      LH: begin
        data     = XLEN'($signed(shifted[15:0]));
        misalign = offset[0];
      end
      LHU: begin
        data     = XLEN'(shifted[15:0]);
        misalign = offset[0];
      end
      LW: begin
        data     = XLEN'($signed(shifted[31:0]));
        misalign = |offset[1:0];
      end
      LWU: begin
        if (XLEN == 64) begin
          data     = XLEN'(shifted[31:0]);
          misalign = |offset[1:0];
        end else begin
          illegal = 1'b1;
        end
      end
      LD: begin
        if (XLEN == 64) begin
          data     = shifted;
          misalign = |offset;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: holds a late load, selects the writeback source and registers the
// register-file write port, load exceptions and the retired-instruction counter.
module wb_unit
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic     clk,
  input  logic     rst,
  wb_unit_if.slave wb
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("wb_unit: XLEN must be 32 or 64");
  end

  logic             is_load;
  logic             wait_ld;
  logic             accept;
  logic             exc;
  logic [XLEN-1:0]  ld_data;
  logic             ld_mis;
  logic             ld_ill;
  logic [XLEN-1:0]  wb_data;

  logic             rf_we_q;
  logic [4:0]       rf_waddr_q;
  logic [XLEN-1:0]  rf_wdata_q;
  logic             exc_mis_q;
  logic             exc_ill_q;
  logic [CNT_W-1:0] instret_q;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3   (wb.Funct3_MW),
    .offset   (wb.ADDR_LO_MW),
    .word     (wb.MEM_DATA_MW),
    .data     (ld_data),
    .misalign (ld_mis),
    .illegal  (ld_ill)
  );

  // A flush wins over a pending load, so a killed load never stalls the pipe.
  assign is_load = (wb.MemtoReg_MW == WB_SRC_MEM);
  assign wait_ld = wb.VALID_MW & is_load & ~wb.MEM_RDY_MW & ~wb.FLUSH_WB;
  assign accept  = wb.VALID_MW & ~wb.FLUSH_WB & ~wait_ld;
  assign exc     = is_load & (ld_mis | ld_ill);

  always_comb begin
    wb_data = wb.RD_VAL_MW;
    case (wb.MemtoReg_MW)
      WB_SRC_ALU: wb_data = wb.RD_VAL_MW;
      WB_SRC_MEM: wb_data = ld_data;
      WB_SRC_PC4: wb_data = wb.PC4_MW;
      default:    wb_data = wb.RD_VAL_MW;
    endcase
  end

  // Address/data only move on accept so the forwarding value stays stable across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      exc_mis_q  <= 1'b0;
      exc_ill_q  <= 1'b0;
      instret_q  <= '0;
    end else begin
      rf_we_q   <= accept & wb.RegWrite_MW & (wb.RD_MW != 5'd0) & ~exc;
      exc_mis_q <= accept & is_load & ld_mis;
      exc_ill_q <= accept & is_load & ld_ill;
      if (accept) begin
        rf_waddr_q <= wb.RD_MW;
        rf_wdata_q <= wb_data;
      end
      if (accept && !exc) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign wb.STALL_WB     = wait_ld & ~rst;
  assign wb.RF_WE        = rf_we_q;
  assign wb.RF_WADDR     = rf_waddr_q;
  assign wb.RF_WDATA     = rf_wdata_q;
  assign wb.EXC_MISALIGN = exc_mis_q;
  assign wb.EXC_ILLEGAL  = exc_ill_q;
  assign wb.INSTRET      = instret_q;

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: directed vectors on an XLEN=32 and an XLEN=64 instance,
// expected results queued per clock edge and compared by per-instance monitors.
module tb_wb_unit;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_unit_if #(.XLEN(32), .CNT_W(64)) if32 ();
  wb_unit_if #(.XLEN(64), .CNT_W(64)) if64 ();

  wb_unit #(.XLEN(32), .CNT_W(64)) dut32 (.clk(clk), .rst(rst), .wb(if32));
  wb_unit #(.XLEN(64), .CNT_W(64)) dut64 (.clk(clk), .rst(rst), .wb(if64));

  typedef struct {
    string       name;
    bit          sel;
    bit          valid;
    bit          rw;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [2:0]  lo;
    logic [63:0] data;
    bit          rdy;
    logic [63:0] pc4;
    logic [63:0] rdval;
    bit          flush;
    bit          eStall;
    bit          eWe;
    logic [63:0] eData;
    bit          eMis;
    bit          eIll;
  } vec_t;

  typedef struct {
    string       name;
    bit          we;
    bit          mis;
    bit          ill;
    bit          chk;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] instret;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  vec_t vecs[$];

  int assertCount = 0;
  int failCount   = 0;

  logic [63:0] expInstret[2];
  logic [4:0]  lastWaddr[2];
  logic [63:0] lastWdata[2];
  bit          lastValid[2];

  localparam logic [63:0] P = 64'h0000_0000_0000_0AA4;
  localparam logic [63:0] R = 64'h0000_0000_0000_0555;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(string name, bit sel, bit valid, bit rw, logic [4:0] rd,
                              logic [1:0] src, logic [2:0] f3, logic [2:0] lo,
                              logic [63:0] data, bit rdy, logic [63:0] pc4,
                              logic [63:0] rdval, bit flush, bit eStall, bit eWe,
                              logic [63:0] eData, bit eMis, bit eIll);
    vec_t v;
    v.name = name; v.sel = sel; v.valid = valid; v.rw = rw; v.rd = rd; v.src = src;
    v.f3 = f3; v.lo = lo; v.data = data; v.rdy = rdy; v.pc4 = pc4; v.rdval = rdval;
    v.flush = flush; v.eStall = eStall; v.eWe = eWe; v.eData = eData;
    v.eMis = eMis; v.eIll = eIll;
    return v;
  endfunction

  task automatic driveIdle();
    if32.VALID_MW = 1'b0; if32.RegWrite_MW = 1'b0; if32.RD_MW = '0; if32.MemtoReg_MW = '0;
    if32.Funct3_MW = '0; if32.ADDR_LO_MW = '0; if32.MEM_DATA_MW = '0; if32.MEM_RDY_MW = 1'b0;
    if32.PC4_MW = '0; if32.RD_VAL_MW = '0; if32.FLUSH_WB = 1'b0;
    if64.VALID_MW = 1'b0; if64.RegWrite_MW = 1'b0; if64.RD_MW = '0; if64.MemtoReg_MW = '0;
    if64.Funct3_MW = '0; if64.ADDR_LO_MW = '0; if64.MEM_DATA_MW = '0; if64.MEM_RDY_MW = 1'b0;
    if64.PC4_MW = '0; if64.RD_VAL_MW = '0; if64.FLUSH_WB = 1'b0;
  endtask

  task automatic resetDuts();
    exp_t e;
    rst = 1'b1;
    #1;
    checkOutput("rst.stall32", 64'(if32.STALL_WB), 64'd0);
    checkOutput("rst.stall64", 64'(if64.STALL_WB), 64'd0);
    @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      expInstret[s] = '0;
      lastWaddr[s]  = '0;
      lastWdata[s]  = '0;
      lastValid[s]  = 1'b1;
    end
    e.name = "reset"; e.we = 1'b0; e.mis = 1'b0; e.ill = 1'b0; e.chk = 1'b1;
    e.waddr = '0; e.wdata = '0; e.instret = '0;
    q32.push_back(e);
    q64.push_back(e);
    #1;
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bit   accept;
    bit   exc;
    int   s;
    s = v.sel ? 1 : 0;
    driveIdle();
    if (s == 0) begin
      if32.VALID_MW = v.valid; if32.RegWrite_MW = v.rw; if32.RD_MW = v.rd;
      if32.MemtoReg_MW = v.src; if32.Funct3_MW = v.f3; if32.ADDR_LO_MW = v.lo[1:0];
      if32.MEM_DATA_MW = v.data[31:0]; if32.MEM_RDY_MW = v.rdy; if32.PC4_MW = v.pc4[31:0];
      if32.RD_VAL_MW = v.rdval[31:0]; if32.FLUSH_WB = v.flush;
    end else begin
      if64.VALID_MW = v.valid; if64.RegWrite_MW = v.rw; if64.RD_MW = v.rd;
      if64.MemtoReg_MW = v.src; if64.Funct3_MW = v.f3; if64.ADDR_LO_MW = v.lo;
      if64.MEM_DATA_MW = v.data; if64.MEM_RDY_MW = v.rdy; if64.PC4_MW = v.pc4;
      if64.RD_VAL_MW = v.rdval; if64.FLUSH_WB = v.flush;
    end
    #1;
    if (s == 0) checkOutput({v.name, ".stall"}, 64'(if32.STALL_WB), 64'(v.eStall));
    else        checkOutput({v.name, ".stall"}, 64'(if64.STALL_WB), 64'(v.eStall));

    accept = v.valid & ~v.flush & ~v.eStall;
    exc    = v.eMis | v.eIll;
    if (accept && !exc) begin
      expInstret[s] = expInstret[s] + 64'd1;
      lastWaddr[s]  = v.rd;
      lastWdata[s]  = v.eData;
      lastValid[s]  = 1'b1;
    end else if (accept) begin
      lastValid[s] = 1'b0;
    end
    e.name = v.name; e.we = v.eWe; e.mis = v.eMis; e.ill = v.eIll;
    e.chk = lastValid[s]; e.waddr = lastWaddr[s]; e.wdata = lastWdata[s];
    e.instret = expInstret[s];

    @(posedge clk);
    if (s == 0) q32.push_back(e);
    else        q64.push_back(e);
    #1;
  endtask

  // Each queued entry describes the outputs after one clock edge; sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q32.size() > 0) begin
      e = q32.pop_front();
      checkOutput({e.name, ".we32"},      64'(if32.RF_WE),        64'(e.we));
      checkOutput({e.name, ".mis32"},     64'(if32.EXC_MISALIGN), 64'(e.mis));
      checkOutput({e.name, ".ill32"},     64'(if32.EXC_ILLEGAL),  64'(e.ill));
      checkOutput({e.name, ".instret32"}, if32.INSTRET,           e.instret);
      if (e.chk) begin
        checkOutput({e.name, ".waddr32"}, 64'(if32.RF_WADDR), 64'(e.waddr));
        checkOutput({e.name, ".wdata32"}, 64'(if32.RF_WDATA), e.wdata);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q64.size() > 0) begin
      e = q64.pop_front();
      checkOutput({e.name, ".we64"},      64'(if64.RF_WE),        64'(e.we));
      checkOutput({e.name, ".mis64"},     64'(if64.EXC_MISALIGN), 64'(e.mis));
      checkOutput({e.name, ".ill64"},     64'(if64.EXC_ILLEGAL),  64'(e.ill));
      checkOutput({e.name, ".instret64"}, if64.INSTRET,           e.instret);
      if (e.chk) begin
        checkOutput({e.name, ".waddr64"}, 64'(if64.RF_WADDR), 64'(e.waddr));
        checkOutput({e.name, ".wdata64"}, if64.RF_WDATA,      e.wdata);
      end
    end
  end

  initial begin
    driveIdle();
    resetDuts();

    //                name           sel v rw rd src          f3   lo data                      rdy pc4          rdval                    fl st we eData                    mis ill
    vecs.push_back(mk("lb_lane3",     0, 1, 1, 5, WB_SRC_MEM, LB,  3, 64'h0000_0000_80AA_BBCC, 1, P,           R,                       0, 0, 1, 64'h0000_0000_FFFF_FF80, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("lhu_wait",   0, 1, 1, 6, WB_SRC_MEM, LHU, 2, 64'h0000_0000_1234_5678, 0, P,           R,                       0, 1, 0, 64'h0,                  0, 0));
    vecs.push_back(mk("lhu_ready",    0, 1, 1, 6, WB_SRC_MEM, LHU, 2, 64'h0000_0000_1234_5678, 1, P,           R,                       0, 0, 1, 64'h0000_0000_0000_1234, 0, 0));
    vecs.push_back(mk("lw_misalign",  0, 1, 1, 7, WB_SRC_MEM, LW,  2, 64'h0000_0000_1234_5678, 1, P,           R,                       0, 0, 0, 64'h0,                  1, 0));
    vecs.push_back(mk("ld_illegal32", 0, 1, 1, 7, WB_SRC_MEM, LD,  0, 64'h0000_0000_1234_5678, 1, P,           R,                       0, 0, 0, 64'h0,                  0, 1));
    vecs.push_back(mk("pc4_rd1",      0, 1, 1, 1, WB_SRC_PC4, LB,  0, 64'h0,                   0, 64'h104,     R,                       0, 0, 1, 64'h0000_0000_0000_0104, 0, 0));
    vecs.push_back(mk("pc4_rd0",      0, 1, 1, 0, WB_SRC_PC4, LB,  0, 64'h0,                   0, 64'h104,     R,                       0, 0, 0, 64'h0000_0000_0000_0104, 0, 0));
    vecs.push_back(mk("alu_src00",    0, 1, 1, 31, WB_SRC_ALU, LB, 0, 64'h0,                   0, P,           64'h0000_0000_DEAD_BEEF, 0, 0, 1, 64'h0000_0000_DEAD_BEEF, 0, 0));
    vecs.push_back(mk("alu_src11",    0, 1, 1, 2, 2'b11,      3'b111, 1, 64'h0,                0, P,           64'h0000_0000_0001_2345, 0, 0, 1, 64'h0000_0000_0001_2345, 0, 0));
    vecs.push_back(mk("lh_neg",       0, 1, 1, 8, WB_SRC_MEM, LH,  0, 64'h0000_0000_0000_8001, 1, P,           R,                       0, 0, 1, 64'h0000_0000_FFFF_8001, 0, 0));
    vecs.push_back(mk("lbu_lane1",    0, 1, 1, 9, WB_SRC_MEM, LBU, 1, 64'h0000_0000_0000_FF00, 1, P,           R,                       0, 0, 1, 64'h0000_0000_0000_00FF, 0, 0));
    vecs.push_back(mk("lb_norw",      0, 1, 0, 10, WB_SRC_MEM, LB, 3, 64'h0000_0000_80AA_BBCC, 1, P,           R,                       0, 0, 0, 64'h0000_0000_FFFF_FF80, 0, 0));
    vecs.push_back(mk("idle",         0, 0, 1, 12, WB_SRC_ALU, LB, 0, 64'h0,                   0, P,           R,                       0, 0, 0, 64'h0,                  0, 0));
    vecs.push_back(mk("flush_wait",   0, 1, 1, 13, WB_SRC_MEM, LW, 0, 64'h0000_0000_CAFE_F00D, 0, P,           R,                       0, 1, 0, 64'h0,                  0, 0));
    vecs.push_back(mk("flush",        0, 1, 1, 13, WB_SRC_MEM, LW, 0, 64'h0000_0000_CAFE_F00D, 0, P,           R,                       1, 0, 0, 64'h0,                  0, 0));
    vecs.push_back(mk("pre_rst_wait", 0, 1, 1, 14, WB_SRC_MEM, LW, 0, 64'h0000_0000_CAFE_F00D, 0, P,           R,                       0, 1, 0, 64'h0,                  0, 0));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset lands while the last load is still waiting for memory.
    resetDuts();

    vecs.delete();
    vecs.push_back(mk("lwu_64",       1, 1, 1, 3, WB_SRC_MEM, LWU, 4, 64'hF000_0001_0000_0000, 1, P,           R,                       0, 0, 1, 64'h0000_0000_F000_0001, 0, 0));
    vecs.push_back(mk("lw_64",        1, 1, 1, 4, WB_SRC_MEM, LW,  4, 64'hF000_0001_0000_0000, 1, P,           R,                       0, 0, 1, 64'hFFFF_FFFF_F000_0001, 0, 0));
    vecs.push_back(mk("ld_64",        1, 1, 1, 7, WB_SRC_MEM, LD,  0, 64'h0123_4567_89AB_CDEF, 1, P,           R,                       0, 0, 1, 64'h0123_4567_89AB_CDEF, 0, 0));
    vecs.push_back(mk("ld_mis64",     1, 1, 1, 7, WB_SRC_MEM, LD,  4, 64'h0123_4567_89AB_CDEF, 1, P,           R,                       0, 0, 0, 64'h0,                  1, 0));
    vecs.push_back(mk("lwu_mis64",    1, 1, 1, 7, WB_SRC_MEM, LWU, 2, 64'h0123_4567_89AB_CDEF, 1, P,           R,                       0, 0, 0, 64'h0,                  1, 0));
    vecs.push_back(mk("f3_111_64",    1, 1, 1, 7, WB_SRC_MEM, 3'b111, 0, 64'h0123_4567_89AB_CDEF, 1, P,        R,                       0, 0, 0, 64'h0,                  0, 1));
    vecs.push_back(mk("lb_lane7_64",  1, 1, 1, 11, WB_SRC_MEM, LB, 7, 64'h7F00_0000_0000_0000, 1, P,           R,                       0, 0, 1, 64'h0000_0000_0000_007F, 0, 0));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    driveIdle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("drain32", 64'(q32.size()), 64'd0);
    checkOutput("drain64", 64'(q64.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
